// File: rtl/input_conditioner.sv
// Board input front end: 2-flop synchronisers and per-bit debounce for slide
// switches and push-buttons, with registered key edge pulses and a switch-change pulse.
module input_conditioner #(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SW-1:0]  switch_raw,
    input  logic [N_KEY-1:0] key_raw,
    output logic [N_SW-1:0]  switch,
    output logic [N_KEY-1:0] key,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic             switch_changed
);

    localparam int N_ALL = N_SW + N_KEY;

    // Keys are flipped after synchronisation so that internally pressed = 1.
    localparam logic [N_KEY-1:0] KEY_INV     = (KEY_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [N_ALL-1:0] SYNC_RESET  = {KEY_INV, {N_SW{1'b0}}};
    localparam logic [N_ALL-1:0] POLARITY    = {KEY_INV, {N_SW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_ALL-1:0] syncFirst;
    logic [N_ALL-1:0] syncSecond;
    logic [N_ALL-1:0] condIn;
    logic [N_ALL-1:0] stab;
    logic [N_ALL-1:0] accept;
    logic [N_ALL-1:0] stabNext;
    logic [CNT_W-1:0] cnt [N_ALL];

    assign condIn = syncSecond ^ POLARITY;

    // A bit is accepted on the edge where it has disagreed with stab for the
    // full debounce window; the counter saturates there and never wraps.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_ALL; i++) begin
            accept[i] = (condIn[i] != stab[i]) && (cnt[i] == CNT_LAST);
        end
        stabNext = stab ^ accept;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            syncFirst      <= SYNC_RESET;
            syncSecond     <= SYNC_RESET;
            stab           <= '0;
            key_press      <= '0;
            key_release    <= '0;
            switch_changed <= 1'b0;
            for (int i = 0; i < N_ALL; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            syncFirst      <= {key_raw, switch_raw};
            syncSecond     <= syncFirst;
            stab           <= stabNext;
            key_press      <= accept[N_ALL-1:N_SW] & ~stab[N_ALL-1:N_SW];
            key_release    <= accept[N_ALL-1:N_SW] & stab[N_ALL-1:N_SW];
            switch_changed <= |accept[N_SW-1:0];
            for (int i = 0; i < N_ALL; i++) begin
                if (condIn[i] == stab[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign switch = stab[N_SW-1:0];
    assign key    = stab[N_ALL-1:N_SW];

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a delay-line/window model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_input_conditioner;

    localparam int N_SW  = 10;
    localparam int N_KEY = 2;
    localparam int DC    = 4;
    localparam int N_ALL = N_SW + N_KEY;
    localparam int W     = N_SW + 3 * N_KEY + 1;

    logic             clk;
    logic             reset_n;
    logic [N_SW-1:0]  switch_raw;
    logic [N_KEY-1:0] key_raw;
    logic [N_SW-1:0]  switch;
    logic [N_KEY-1:0] key;
    logic [N_KEY-1:0] key_press;
    logic [N_KEY-1:0] key_release;
    logic             switch_changed;

    input_conditioner #(
        .N_SW(N_SW), .N_KEY(N_KEY), .DEBOUNCE_CYCLES(DC), .CNT_W(20), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .switch_raw(switch_raw), .key_raw(key_raw),
        .switch(switch), .key(key), .key_press(key_press), .key_release(key_release),
        .switch_changed(switch_changed)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int sc_count = 0;

    logic [W-1:0]     exp_q[$];

    // reference model state: raw samples ride a 2-deep delay line, and a
    // bit flips once its last DC delayed samples all disagree with it
    logic [N_ALL-1:0] sync_q[$];
    logic [N_ALL-1:0] hist[$];
    logic [N_ALL-1:0] m_stab;

    task automatic model_step();
        logic [N_ALL-1:0] pressed, s, newv;
        logic [N_KEY-1:0] m_press, m_rel;
        logic             m_chg;
        bit               all_differ;
        pressed = {~key_raw, switch_raw};
        m_press = '0;
        m_rel   = '0;
        m_chg   = 1'b0;
        if (!reset_n) begin
            sync_q.delete();
            sync_q.push_back('0);
            sync_q.push_back('0);
            hist.delete();
            m_stab = '0;
        end else begin
            s = sync_q.pop_front();
            sync_q.push_back(pressed);
            hist.push_back(s);
            if (hist.size() > DC) void'(hist.pop_front());
            newv = m_stab;
            if (hist.size() == DC) begin
                for (int i = 0; i < N_ALL; i++) begin
                    all_differ = 1'b1;
                    foreach (hist[j]) if (hist[j][i] == m_stab[i]) all_differ = 1'b0;
                    if (all_differ) newv[i] = ~m_stab[i];
                end
            end
            m_press = newv[N_ALL-1:N_SW] & ~m_stab[N_ALL-1:N_SW];
            m_rel   = ~newv[N_ALL-1:N_SW] & m_stab[N_ALL-1:N_SW];
            m_chg   = |(newv[N_SW-1:0] ^ m_stab[N_SW-1:0]);
            m_stab  = newv;
        end
        exp_q.push_back({m_stab[N_SW-1:0], m_stab[N_ALL-1:N_SW], m_press, m_rel, m_chg});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // scoreboard monitor
    initial forever begin
        logic [W-1:0] got, exp;
        @(negedge clk);
        cycle++;
        got = {switch, key, key_press, key_release, switch_changed};
        if (switch_changed === 1'b1) sc_count++;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty cycle %0d got %h required an expected entry", cycle, got);
        end else begin
            exp = exp_q.pop_front();
            if (got === exp) n_pass++;
            else $display("FAIL outputs cycle %0d got sw=%h key=%b prs=%b rel=%b chg=%b required sw=%h key=%b prs=%b rel=%b chg=%b",
                          cycle, got[16:7], got[6:5], got[4:3], got[2:1], got[0],
                          exp[16:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_count(input string name, input int got, input int req);
        n_checks++;
        if (got == req) n_pass++;
        else $display("FAIL %s got %0d required %0d", name, got, req);
    endtask

    initial begin
        int base, hold;
        reset_n    = 1'b0;
        switch_raw = '1;
        key_raw    = 2'b00;
        #2;
        tick(2);
        reset_n = 1'b1;
        base = sc_count;
        tick(12);
        check_count("reset_release_switch_changed", sc_count - base, 1);

        // clean press and release of key 1
        key_raw = 2'b11;
        tick(10);
        key_raw = 2'b01;
        tick(10);
        key_raw = 2'b11;
        tick(10);

        // bounce on switch bit 3
        switch_raw = '0;
        tick(10);
        base = sc_count;
        for (int b = 0; b < 4; b++) begin
            switch_raw[3] = b[0];
            tick(2);
        end
        switch_raw[3] = 1'b1;
        tick(10);
        check_count("bounce_single_change", sc_count - base, 1);

        // 3-cycle glitch on bit 0
        base = sc_count;
        switch_raw[0] = 1'b1;
        tick(3);
        switch_raw[0] = 1'b0;
        tick(10);
        check_count("glitch_rejected", sc_count - base, 0);

        // reset in the middle of a key-0 count
        key_raw[0] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(10);
        key_raw = 2'b11;
        switch_raw = '0;
        tick(12);

        // sweep
        base = sc_count;
        for (int v = 0; v < 256; v++) begin
            switch_raw = N_SW'(v);
            tick(10);
        end
        check_count("sweep_changes", sc_count - base, 255);

        // randomized bouncing with occasional resets
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 3) == 0) switch_raw = N_SW'($urandom);
            if ($urandom_range(0, 3) == 0) key_raw = N_KEY'($urandom);
            reset_n = ($urandom_range(0, 49) != 0);
            hold = $urandom_range(1, 7);
            tick(hold);
        end
        reset_n = 1'b1;
        tick(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Upstream front end for design1. Takes raw board switches and push-buttons, synchronises them to the system clock and debounces every bit. Produces clean switch levels plus single-cycle key press/release pulses for design1's switch and key inputs. One instance sits between the top-level pins and design1.

Parameters:
N_SW, 10, number of slide-switch bits
N_KEY, 2, number of push-button bits
DEBOUNCE_CYCLES, 500000, cycles a synchronised input must hold a new value before it is accepted (10 ms at 50 MHz); legal range 2..2^CNT_W-1
CNT_W, 20, width of each per-bit debounce counter
KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (board default); 0 = raw key reads 1 when pressed

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
switch_raw  in  N_SW  asynchronous slide-switch pins
key_raw  in  N_KEY  asynchronous push-button pins
switch  out  N_SW  debounced switch levels, to design1.switch
key  out  N_KEY  debounced key levels, active-high pressed, to design1.key
key_press  out  N_KEY  one-cycle pulse per bit on accepted released->pressed edge
key_release  out  N_KEY  one-cycle pulse per bit on accepted pressed->released edge
switch_changed  out  1  one-cycle pulse when any bit of switch changes

Behaviour:
- Synchroniser: 2-flop chain per raw bit.
  - Reset values: switch chains 0; key chains at the released level (1 if KEY_ACTIVE_LOW, else 0).
- Key polarity: applied after synchronisation, so internally pressed = 1.
- Debounce: identical per bit, independent counter cnt[CNT_W-1:0] and accepted level stab.
  - sync == stab: cnt <= 0.
  - sync != stab and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync != stab and cnt == DEBOUNCE_CYCLES-1: stab <= sync, cnt <= 0.
  - Any return of sync to stab before acceptance clears cnt. Glitches shorter than DEBOUNCE_CYCLES synchronised cycles are fully rejected.
- Latency: raw change first sampled at edge k, held steady → output changes at edge k+1+DEBOUNCE_CYCLES. Total 2 sync + DEBOUNCE_CYCLES-1 count cycles.
- Outputs are registered: switch = stab_sw, key = stab_key.
- key_press[i]: high for exactly the cycle after key[i] goes 0->1; 0 otherwise. key_release[i] likewise for 1->0.
- switch_changed: high for exactly one cycle after any switch bit updates. Multiple bits updating on the same edge give a single pulse.
- Per-bit independence: simultaneous activity on different bits never interacts. Two keys accepted on the same edge pulse their key_press bits in the same cycle.
- Counter never wraps: saturates by construction at DEBOUNCE_CYCLES-1.
- Reset (any time, including mid-count) forces on the next edge:
  - all counters 0;
  - switch = 0, key = 0;
  - key_press = key_release = 0, switch_changed = 0;
  - sync chains to their reset values.
- After reset, a switch already up at power-on is accepted after the normal latency and produces switch_changed. A key held through reset is reported as a fresh press after the normal latency.
- No combinational path from any input to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, clk 10 ns.

1. Reset: reset_n=0 for 2 cycles with switch_raw=10'h3FF, key_raw=2'b00 → switch=0, key=0, all pulses 0 during reset. Release reset → switch=10'h3FF, key=2'b11 at edge 5 after release. switch_changed and key_press=2'b11 each pulse for exactly 1 cycle.
2. Clean press: key_raw[1] 1->0 held → key[1]=1 exactly 5 edges later, key_press=2'b10 for one cycle. Raw back to 1 → key_release=2'b10 for one cycle after the same latency.
3. Bounce rejection: switch_raw[3] toggles 0,1,0,1 every 2 cycles, then holds 1 → switch[3] stays 0 throughout bouncing. Rises only 5 edges after the final stable 1; single switch_changed pulse.
4. Glitch: switch_raw[0] high for 3 cycles, then low → switch[0] never changes, switch_changed never pulses.
5. Mid-count reset: key_raw[0] pressed; assert reset_n=0 at count 2 for 1 cycle; raw still pressed → key[0]=0 and cnt=0 after reset. key[0]=1 with one key_press pulse 5 edges after reset release.
6. Sweep: switch_raw counts 0..255, each value held 10 cycles → switch equals each value 5 cycles after its application. Exactly 255 switch_changed pulses; key outputs remain 0.
